// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared encodings for the sequential ALU: alu_op selectors, funct3/funct7
// constants, the FSM state type and the internal operation enum.
// Optional feature macro: ALU_SEQ_DIV_EN (adds the DIV state).

package alu_seq_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd3
    } state_t;
`endif

    typedef enum logic [4:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND,
        OP_MUL,
        OP_MULH,
        OP_MULHSU,
        OP_MULHU,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU
    } op_t;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode
// Combinational decode of {alu_op, funct7, funct3} into the internal op
// enum plus per-operand signedness flags used by the iterative datapath.
// Ports:
//   alu_op_i  - 00 add, 01 sub, 10 R-type, 11 I-type
//   funct3_i  - instruction funct3
//   funct7_i  - instruction funct7
//   op_o      - decoded operation (OP_NONE for unsupported encodings)
//   sgn_a_o   - operand1 is treated as signed by mul/div
//   sgn_b_o   - operand2 is treated as signed by mul/div
// Optional feature macro: ALU_SEQ_DIV_EN (without it div/rem decode to OP_NONE).

module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output op_t        op_o,
    output logic       sgn_a_o,
    output logic       sgn_b_o
);

    always_comb begin
        op_o    = OP_NONE;
        sgn_a_o = 1'b0;
        sgn_b_o = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: op_o = OP_ADD;
            ALUOP_SUB: op_o = OP_SUB;
            ALUOP_R: begin
                if (funct7_i == F7_MULDIV) begin
                    case (funct3_i)
                        F3_MUL:    op_o = OP_MUL;
                        F3_MULH: begin
                            op_o    = OP_MULH;
                            sgn_a_o = 1'b1;
                            sgn_b_o = 1'b1;
                        end
                        F3_MULHSU: begin
                            op_o    = OP_MULHSU;
                            sgn_a_o = 1'b1;
                        end
                        F3_MULHU:  op_o = OP_MULHU;
`ifdef ALU_SEQ_DIV_EN
                        F3_DIV: begin
                            op_o    = OP_DIV;
                            sgn_a_o = 1'b1;
                            sgn_b_o = 1'b1;
                        end
                        F3_DIVU:   op_o = OP_DIVU;
                        F3_REM: begin
                            op_o    = OP_REM;
                            sgn_a_o = 1'b1;
                            sgn_b_o = 1'b1;
                        end
                        F3_REMU:   op_o = OP_REMU;
`endif
                        default:   op_o = OP_NONE;
                    endcase
                end else if (funct7_i == F7_BASE) begin
                    case (funct3_i)
                        F3_ADD_SUB: op_o = OP_ADD;
                        F3_SLL:     op_o = OP_SLL;
                        F3_SLT:     op_o = OP_SLT;
                        F3_SLTU:    op_o = OP_SLTU;
                        F3_XOR:     op_o = OP_XOR;
                        F3_SR:      op_o = OP_SRL;
                        F3_OR:      op_o = OP_OR;
                        F3_AND:     op_o = OP_AND;
                        default:    op_o = OP_NONE;
                    endcase
                end else if (funct7_i == F7_ALT) begin
                    if (funct3_i == F3_ADD_SUB) begin
                        op_o = OP_SUB;
                    end else if (funct3_i == F3_SR) begin
                        op_o = OP_SRA;
                    end
                end
            end
            ALUOP_I: begin
                // funct7 only matters for the shift-right flavour; for the
                // other immediate ops those bits belong to the immediate.
                case (funct3_i)
                    F3_ADD_SUB: op_o = OP_ADD;
                    F3_SLL:     op_o = OP_SLL;
                    F3_SLT:     op_o = OP_SLT;
                    F3_SLTU:    op_o = OP_SLTU;
                    F3_XOR:     op_o = OP_XOR;
                    F3_SR:      op_o = funct7_i[5] ? OP_SRA : OP_SRL;
                    F3_OR:      op_o = OP_OR;
                    F3_AND:     op_o = OP_AND;
                    default:    op_o = OP_NONE;
                endcase
            end
            default: op_o = OP_NONE;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Handshaked execute-stage ALU: RV32I integer ops in one cycle, RV32M
// multiply (and optionally divide) iteratively, one bit per cycle.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   in_valid / in_ready    - request handshake
//   read_data1             - operand1
//   read_data2, imm        - operand2 sources, chosen by alu_src
//   alu_op, funct3, funct7 - operation select
//   out_valid / out_ready  - result handshake
//   alu_result, zero       - registered result and result==0 flag
//   busy                   - iterative op in progress
// Optional feature macro: ALU_SEQ_DIV_EN (divider datapath and DIV state).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting requests; single-cycle results load on accept
// MUL   | shift-add multiply step per cycle, counter WIDTH..1
// DIV   | restoring-divide step per cycle, counter WIDTH..1
// FIX   | sign correction, half/quotient/remainder select, load output

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             busy
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q;
    logic               out_valid_q;
    logic               zero_q;
    logic               busy_q;
    logic               neg_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [CNT_W-1:0]   cnt_q;
    op_t                op_q;

    op_t                op_dec;
    logic               sgn_a;
    logic               sgn_b;
    logic               accept;
    logic               is_mul;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [SH_W-1:0]    shamt;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   single_res;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_res;

    alu_seq_decode u_decode (
        .alu_op_i (alu_op),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .op_o     (op_dec),
        .sgn_a_o  (sgn_a),
        .sgn_b_o  (sgn_b)
    );

    assign opa   = read_data1;
    assign opb   = alu_src ? imm : read_data2;
    assign shamt = opb[SH_W-1:0];

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};

    // Iteration runs on magnitudes; the sign is re-applied in FIX.
    assign neg_a = sgn_a & opa[WIDTH-1];
    assign neg_b = sgn_b & opb[WIDTH-1];
    assign mag_a = neg_a ? (~opa + 1'b1) : opa;
    assign mag_b = neg_b ? (~opb + 1'b1) : opb;

`ifdef ALU_SEQ_DIV_EN
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             is_div;
    logic             is_rem;
    logic             div_by_zero;
    logic             div_ovf;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi_next;
    logic [WIDTH-1:0] div_lo_next;

    assign is_div      = op_dec inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign is_rem      = op_dec inside {OP_REM, OP_REMU};
    assign div_by_zero = (opb == '0);
    assign div_ovf     = sgn_a && (opa == SMIN) && (opb == '1);

    // Restoring step: shift the partial remainder left by one dividend bit,
    // keep the difference only if the divisor fits.  When it fits the true
    // difference is below the divisor, so the wrapped W-bit subtract is exact.
    assign div_shift   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge      = (div_shift >= {1'b0, opnd_q});
    assign div_diff    = div_shift[WIDTH-1:0] - opnd_q;
    assign div_hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_next = {acc_lo_q[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        single_res = '0;
        case (op_dec)
            OP_ADD:  single_res = opa + opb;
            OP_SUB:  single_res = opa - opb;
            OP_SLL:  single_res = opa << shamt;
            OP_SLT:  single_res = WIDTH'($signed(opa) < $signed(opb));
            OP_SLTU: single_res = WIDTH'(opa < opb);
            OP_XOR:  single_res = opa ^ opb;
            OP_SRL:  single_res = opa >> shamt;
            OP_SRA:  single_res = $unsigned($signed(opa) >>> shamt);
            OP_OR:   single_res = opa | opb;
            OP_AND:  single_res = opa & opb;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV, OP_DIVU: begin
                if (div_by_zero) begin
                    single_res = '1;
                end else if (div_ovf) begin
                    single_res = SMIN;
                end
            end
            OP_REM, OP_REMU: begin
                if (div_by_zero) begin
                    single_res = opa;
                end
            end
`endif
            default: single_res = '0;
        endcase
    end

    // Shift-add step: {carry, hi, lo} shifts right one place after
    // conditionally adding the multiplicand into the high half.
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_lo_q[WIDTH-1:1]};

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;

    always_comb begin
        fix_res = prod_fix[WIDTH-1:0];
        case (op_q)
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
            OP_DIV, OP_DIVU: fix_res = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
            OP_REM, OP_REMU: fix_res = neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
`endif
            default: fix_res = prod_fix[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            neg_q       <= 1'b0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            op_q        <= OP_NONE;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q  <= ST_MUL;
                            busy_q   <= 1'b1;
                            cnt_q    <= CNT_W'(WIDTH);
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_b;
                            opnd_q   <= mag_a;
                            op_q     <= op_dec;
                            neg_q    <= neg_a ^ neg_b;
                        end
`ifdef ALU_SEQ_DIV_EN
                        else if (is_div && !div_by_zero && !div_ovf) begin
                            state_q  <= ST_DIV;
                            busy_q   <= 1'b1;
                            cnt_q    <= CNT_W'(WIDTH);
                            acc_hi_q <= '0;
                            acc_lo_q <= mag_a;
                            opnd_q   <= mag_b;
                            op_q     <= op_dec;
                            // Remainder takes the dividend's sign.
                            neg_q    <= is_rem ? neg_a : (neg_a ^ neg_b);
                        end
`endif
                        else begin
                            result_q    <= single_res;
                            zero_q      <= (single_res == '0);
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    {acc_hi_q, acc_lo_q} <= mul_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    acc_hi_q <= div_hi_next;
                    acc_lo_q <= div_lo_next;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_FIX;
                    end
                end
`endif
                ST_FIX: begin
                    result_q    <= fix_res;
                    zero_q      <= (fix_res == '0);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = result_q;
    assign zero       = zero_q;
    assign busy       = busy_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle ALU in the execute stage. Covers the full RV32I integer op set plus RV32M multiply, and optionally divide.
- Multiply and divide run iteratively, one bit per cycle.
- Valid/ready on input and output lets the pipeline control stall the execute stage while the block is busy.

Parameters:
WIDTH, 32, operand/result width; must be ≥8 and a power of two; shift amount uses low log2(WIDTH) bits of operand2.
CNT_W, $clog2(WIDTH)+1, localparam; iteration counter width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  block accepts request this cycle
read_data1  in  WIDTH  operand1
read_data2  in  WIDTH  register operand2
imm  in  WIDTH  immediate operand2
alu_src  in  1  1: operand2=imm, 0: operand2=read_data2
alu_op  in  2  00 add (ld/st), 01 sub (branch), 10 R-type decode, 11 I-type decode
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
out_valid  out  1  result held
out_ready  in  1  consumer takes result
alu_result  out  WIDTH  registered result
zero  out  1  alu_result==0, registered with result
busy  out  1  iterative op in progress

Behaviour:
- Reset (async, rst_n low): state=IDLE, out_valid=0, alu_result=0, zero=1, busy=0, counter=0. Asserting reset mid-iteration abandons the op; no output is produced.
- Accept condition: accept = in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A back-to-back single-cycle stream runs at 1 op/cycle.
- Output handshake: out_valid, alu_result and zero hold stable until out_valid && out_ready. Output clears the cycle after acceptance unless a new result loads that same edge.
- Decode, alu_op=10, {funct7,funct3}:
  - 0000000_000 add; 0100000_000 sub; 0000000_001 sll; 0000000_010 slt; 0000000_011 sltu
  - 0000000_100 xor; 0000000_101 srl; 0100000_101 sra; 0000000_110 or; 0000000_111 and
  - 0000001_0xx mul/mulh/mulhsu/mulhu; 0000001_1xx div/divu/rem/remu
- Decode, alu_op=11: same ops by funct3 only, except funct3=101, where funct7[5] selects sra. There is no sub and no M ops.
- Unsupported encodings yield result 0 with latency 1.
- Single-cycle ops: the result registers on the accept edge; out_valid is high the next cycle (latency 1).
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on an accepted M-mul op; IDLE→DIV on an accepted div/rem op.
  - MUL/DIV: operate on magnitudes according to each operand's signedness. One shift-add (MUL) or restoring-subtract (DIV) step per cycle, counter WIDTH down to 1.
  - When the counter reaches 1, go to FIX.
  - FIX: apply sign correction, select low/high half or quotient/remainder, load the output, set out_valid, return to IDLE.
  - Latency of an iterative op: WIDTH+2 cycles from accept to out_valid. busy=1 in MUL/DIV/FIX.
- Divide special cases, resolved at accept with no iteration (latency 1):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed MIN / -1: quotient = MIN; remainder = 0.
- Widths: all arithmetic wraps modulo 2^WIDTH. MULH* returns product bits [2W-1:W].

Optional Feature:
ALU_SEQ_DIV_EN
- Defined: DIV state and divider datapath present; div/divu/rem/remu behave as above.
- Undefined: DIV state and divider datapath omitted. Div/rem encodings are treated as unsupported (result 0, latency 1). The multiplier is unaffected.

Decomposition:
- Package alu_seq_pkg holds:
  - the alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I);
  - funct3/funct7 constants;
  - the FSM state typedef;
  - the internal op enum (OP_ADD … OP_REMU).
- One sub-module, alu_seq_decode: combinational {alu_op,funct7,funct3} → op enum plus signedness flags. The datapath and FSM stay in alu_seq.

Test Plan:
- Reset mid-op: issue div 100/7, pull rst_n low on cycle 10 → out_valid=0, zero=1, in_ready=1 after release; no stale result appears.
- R-type stream, out_ready=1: add 5+3, sub 3-5, sra 0x80000000>>>4, sltu 1<2 on consecutive cycles → 8, 0xFFFFFFFE, 0xF8000000, 1 at 1/cycle; zero=0 for each.
- Backpressure: out_ready=0 after result 0 (sub 7-7) → alu_result=0 and zero=1 held, in_ready=0; release → next op accepted the same cycle.
- mulh -2*3 (WIDTH=32) → 0xFFFFFFFF at exactly 34 cycles; mul 0xFFFF*0xFFFF → 0xFFFE0001. in_ready stays low throughout.
- Divide corners with ALU_SEQ_DIV_EN: div -7/2 → 0xFFFFFFFD; rem -7/2 → 0xFFFFFFFF; divu 9/0 → 0xFFFFFFFF at latency 1; div 0x80000000/-1 → 0x80000000.
- Without ALU_SEQ_DIV_EN: div 9/3 → 0, latency 1, busy never asserted; alu_op=11 funct3=000 with imm=-1 on 1 → 0, zero=1.
